// File: rtl/output_port_arbiter_rr_pkg.sv
// Shared definitions for the output port arbiter: port index constants,
// default widths and the packed-packet field layout used by the FIFOs.
// Optional single-edge bypass is enabled with the OPA_BYPASS_EN macro.
package output_port_arbiter_rr_pkg;

    typedef enum logic [2:0] {
        OPA_PORT_NORTH = 3'd0,
        OPA_PORT_SOUTH = 3'd1,
        OPA_PORT_EAST  = 3'd2,
        OPA_PORT_WEST  = 3'd3,
        OPA_PORT_CACHE = 3'd4
    } opa_port_e;

    localparam int OPA_DEF_NUM_INPUTS = 5;
    localparam int OPA_DEF_DEST_W     = 8;
    localparam int OPA_DEF_REQ_W      = 4;
    localparam int OPA_DEF_DATA_W     = 32;
    localparam int OPA_DEF_FIFO_DEPTH = 4;

    // Packed packet layout, LSB first: data | write | read | req | dest
    function automatic int opa_off_write(input int data_w);
        return data_w;
    endfunction

    function automatic int opa_off_read(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int opa_off_req(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int opa_off_dest(input int data_w, input int req_w);
        return data_w + 2 + req_w;
    endfunction

    function automatic int opa_pkt_w(input int dest_w, input int req_w, input int data_w);
        return dest_w + req_w + 2 + data_w;
    endfunction

endpackage

// File: rtl/output_port_arbiter_rr_fifo.sv
// opa_fifo: single-clock FIFO (falling-edge state updates, async active-high
// reset) with push/pop/full/empty/count. Same-cycle push and pop keep count.
module opa_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (natural wrap) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(negedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and count registers
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/output_port_arbiter_rr.sv
// Round-robin output port arbiter: one FIFO per input, fair search from
// rr_ptr, registered output with back-pressure. Falling-edge state updates.
// Define OPA_BYPASS_EN to let an empty-FIFO input go straight to the output.
module output_port_arbiter_rr
    import output_port_arbiter_rr_pkg::*;
#(
    parameter int NUM_INPUTS = OPA_DEF_NUM_INPUTS,
    parameter int DEST_W     = OPA_DEF_DEST_W,
    parameter int REQ_W      = OPA_DEF_REQ_W,
    parameter int DATA_W     = OPA_DEF_DATA_W,
    parameter int FIFO_DEPTH = OPA_DEF_FIFO_DEPTH,
    parameter int SRC_W      = $clog2(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_INPUTS-1:0]        in_valid,
    output logic [NUM_INPUTS-1:0]        in_ready,
    input  logic [NUM_INPUTS*DEST_W-1:0] in_dest,
    input  logic [NUM_INPUTS*REQ_W-1:0]  in_req,
    input  logic [NUM_INPUTS-1:0]        in_read,
    input  logic [NUM_INPUTS-1:0]        in_write,
    input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEST_W-1:0]            out_dest,
    output logic [REQ_W-1:0]             out_req,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_read,
    output logic                         out_write,
    output logic [SRC_W-1:0]             out_src,
    output logic [NUM_INPUTS-1:0]        fifo_full
);
    localparam int PKT_W    = opa_pkt_w(DEST_W, REQ_W, DATA_W);
    localparam int OFF_WR   = opa_off_write(DATA_W);
    localparam int OFF_RD   = opa_off_read(DATA_W);
    localparam int OFF_REQ  = opa_off_req(DATA_W);
    localparam int OFF_DEST = opa_off_dest(DATA_W, REQ_W);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    logic [PKT_W-1:0]      in_pkt       [NUM_INPUTS];
    logic [PKT_W-1:0]      fifo_rd_data [NUM_INPUTS];
    logic [CNT_W-1:0]      fifo_count   [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] fifo_push, fifo_pop, fifo_empty, bypass_take, eligible;

    logic                  found, load, take;
    logic [SRC_W-1:0]      grant, cand;
    logic [SRC_W:0]        cand_sum;
    logic [PKT_W-1:0]      grant_pkt;

    logic                  out_valid_q, out_valid_d;
    logic                  out_read_q, out_read_d;
    logic                  out_write_q, out_write_d;
    logic [DEST_W-1:0]     out_dest_q, out_dest_d;
    logic [REQ_W-1:0]      out_req_q, out_req_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [SRC_W-1:0]      out_src_q, out_src_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
            assign in_pkt[gi] = {in_dest[gi*DEST_W +: DEST_W], in_req[gi*REQ_W +: REQ_W],
                                 in_read[gi], in_write[gi], in_data[gi*DATA_W +: DATA_W]};

            opa_fifo #(
                .WIDTH (PKT_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (fifo_push[gi]),
                .push_data (in_pkt[gi]),
                .pop       (fifo_pop[gi]),
                .pop_data  (fifo_rd_data[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .count     (fifo_count[gi])
            );

            // Occupancy and empty flag must always agree
            always_comb begin
                assert (fifo_empty[gi] == (fifo_count[gi] == '0));
            end
        end
    endgenerate

    assign in_ready  = reset ? '0 : ~fifo_full;
    assign out_valid = out_valid_q;
    assign out_read  = out_read_q;
    assign out_write = out_write_q;
    assign out_dest  = out_dest_q;
    assign out_req   = out_req_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    // Inputs eligible for the round-robin search
    always_comb begin
        eligible = ~fifo_empty;
`ifdef OPA_BYPASS_EN
        eligible = eligible | (fifo_empty & in_valid);
`endif
    end

    // First eligible input at or after rr_ptr, modulo NUM_INPUTS
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        cand_sum = '0;
        cand     = '0;
        for (int unsigned off = 0; off < NUM_INPUTS; off++) begin
            cand_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(off);
            if (cand_sum >= (SRC_W+1)'(NUM_INPUTS)) begin
                cand_sum = cand_sum - (SRC_W+1)'(NUM_INPUTS);
            end
            cand = cand_sum[SRC_W-1:0];
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Pop/push/bypass steering and output register next-state
    always_comb begin
        load        = !out_valid_q || out_ready;
        take        = load && found;
        grant_pkt   = fifo_rd_data[grant];
        fifo_pop    = '0;
        bypass_take = '0;
        if (take) begin
`ifdef OPA_BYPASS_EN
            if (fifo_empty[grant]) begin
                bypass_take[grant] = 1'b1;
                grant_pkt          = in_pkt[grant];
            end else begin
                fifo_pop[grant] = 1'b1;
            end
`else
            fifo_pop[grant] = 1'b1;
`endif
        end
        fifo_push = in_valid & in_ready & ~bypass_take;

        out_valid_d = out_valid_q;
        out_read_d  = out_read_q;
        out_write_d = out_write_q;
        out_dest_d  = out_dest_q;
        out_req_d   = out_req_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_data_d  = grant_pkt[DATA_W-1:0];
                out_write_d = grant_pkt[OFF_WR];
                out_read_d  = grant_pkt[OFF_RD];
                out_req_d   = grant_pkt[OFF_REQ +: REQ_W];
                out_dest_d  = grant_pkt[OFF_DEST +: DEST_W];
                out_src_d   = grant;
                rr_ptr_d    = (grant == SRC_W'(NUM_INPUTS-1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_read_q  <= 1'b0;
            out_write_q <= 1'b0;
            out_dest_q  <= '0;
            out_req_q   <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_read_q  <= out_read_d;
            out_write_q <= out_write_d;
            out_dest_q  <= out_dest_d;
            out_req_q   <= out_req_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter_rr.sv
// Directed bench for output_port_arbiter_rr (default parameters). Inputs are
// driven and outputs checked 1 time unit after each falling (active) edge.
module tb_output_port_arbiter_rr;
    localparam int N  = 5;
    localparam int DW = 8;
    localparam int RW = 4;
    localparam int XW = 32;
`ifdef OPA_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b1;
    logic            reset;
    logic [N-1:0]    in_valid, in_ready, in_read, in_write, fifo_full;
    logic [N*DW-1:0] in_dest;
    logic [N*RW-1:0] in_req;
    logic [N*XW-1:0] in_data;
    logic            out_valid, out_ready, out_read, out_write;
    logic [DW-1:0]   out_dest;
    logic [RW-1:0]   out_req;
    logic [XW-1:0]   out_data;
    logic [2:0]      out_src;

    int n_checks = 0;
    int n_fail   = 0;

    output_port_arbiter_rr #(
        .NUM_INPUTS (N),
        .DEST_W     (DW),
        .REQ_W      (RW),
        .DATA_W     (XW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_req    (in_req),
        .in_read   (in_read),
        .in_write  (in_write),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dest  (out_dest),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_read  (out_read),
        .out_write (out_write),
        .out_src   (out_src),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [DW-1:0] d, input logic [RW-1:0] r,
                           input logic rd, input logic wr, input logic [XW-1:0] x);
        in_dest[i*DW +: DW] = d;
        in_req[i*RW +: RW]  = r;
        in_read[i]          = rd;
        in_write[i]         = wr;
        in_data[i*XW +: XW] = x;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_dest  = '0;
        in_req   = '0;
        in_read  = '0;
        in_write = '0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        clear_inputs();
        out_ready = 1'b1;
        reset     = 1'b1;
        #2;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        tick();
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_src", out_src, 0);
        check_eq("rst_out_dest", out_dest, 0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 5'h1f);
        check_eq("post_rst_fifo_full", fifo_full, 0);

        // Single input on N
        tick();
        set_pkt(0, 8'h12, 4'h5, 1'b1, 1'b0, 32'hDEADBEEF);
        in_valid[0] = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            in_valid = '0;
            if (e < LAT) check_eq("single_early_valid", out_valid, 0);
        end
        check_eq("single_valid", out_valid, 1);
        check_eq("single_src", out_src, 0);
        check_eq("single_dest", out_dest, 8'h12);
        check_eq("single_req", out_req, 4'h5);
        check_eq("single_read", out_read, 1);
        check_eq("single_write", out_write, 0);
        check_eq("single_data", out_data, 32'hDEADBEEF);
        tick();
        check_eq("single_drained", out_valid, 0);
        check_eq("single_hold_data", out_data, 32'hDEADBEEF);

        // Fairness: all inputs valid every cycle
        do_reset();
        for (int i = 0; i < N; i++) set_pkt(i, 8'(i), 4'(i), 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
        in_valid = '1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k < LAT) begin
                check_eq("rr_early_valid", out_valid, 0);
            end else begin
                check_eq("rr_valid", out_valid, 1);
                check_eq("rr_src", out_src, 64'((k - LAT) % N));
                check_eq("rr_data", out_data, 64'(32'hA000_0000 + 32'((k - LAT) % N)));
            end
        end

        // Stall with input 2 pushing continuously; data = cycle index
        do_reset();
        out_ready   = 1'b0;
        in_valid[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            set_pkt(2, 8'h22, 4'h2, 1'b0, 1'b0, 32'(e - 1));
            tick();
            check_eq("stall_in_ready2", in_ready[2], (e < 5) ? 1 : 0);
            check_eq("stall_full2", fifo_full[2], (e < 5) ? 0 : 1);
            if (e >= LAT) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data_held", out_data, 0);
            end
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            tick();
            if (r <= 4) begin
                check_eq("drain_valid", out_valid, 1);
                check_eq("drain_data", out_data, 64'(r));
                check_eq("drain_src", out_src, 2);
                check_eq("drain_in_ready2", in_ready[2], 1);
            end else begin
                check_eq("drain_empty", out_valid, 0);
            end
        end

        // FIFO wrap: continuous push/pop on input 1
        do_reset();
        for (int e = 1; e <= 11 + LAT; e++) begin
            if (e <= 12) begin
                in_valid[1] = 1'b1;
                set_pkt(1, 8'h11, 4'h1, 1'b1, 1'b1, 32'(e - 1));
            end else begin
                in_valid = '0;
            end
            tick();
            check_eq("wrap_not_full", fifo_full[1], 0);
            if (e >= LAT) begin
                check_eq("wrap_valid", out_valid, 1);
                check_eq("wrap_data", out_data, 64'(e - LAT));
            end
        end
        in_valid = '0;
        tick();
        check_eq("wrap_done", out_valid, 0);

        // Reset mid-stream with packets buffered
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_pkt(i, 8'hC0 + 8'(i), 4'hC, 1'b0, 1'b1, 32'hC0DE_0000 + 32'(i));
        in_valid = 3'b111;
        tick();
        tick();
        in_valid = '0;
        check_eq("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_in_ready", in_ready, 0);
        check_eq("async_rst_data", out_data, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            check_eq("no_stale_pkt", out_valid, 0);
        end
        set_pkt(0, 8'h01, 4'h0, 1'b0, 1'b0, 32'h1000);
        set_pkt(4, 8'h04, 4'h4, 1'b0, 1'b0, 32'h4000);
        in_valid = 5'b10001;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            in_valid = '0;
        end
        check_eq("rr_restart_src0", out_src, 0);
        tick();
        check_eq("rr_restart_src4", out_src, 4);
        check_eq("rr_restart_data4", out_data, 32'h4000);

        // Sparse contention after rr_ptr reaches 2
        do_reset();
        set_pkt(1, 8'h31, 4'h1, 1'b0, 1'b0, 32'h0001_0001);
        in_valid = 5'b00010;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            in_valid = '0;
        end
        check_eq("sparse_prime_src", out_src, 1);
        tick();
        check_eq("sparse_prime_drained", out_valid, 0);
        set_pkt(1, 8'h31, 4'h1, 1'b0, 1'b0, 32'h0001_0002);
        set_pkt(3, 8'h33, 4'h3, 1'b1, 1'b0, 32'h0003_0002);
        in_valid = 5'b01010;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            in_valid = '0;
        end
        check_eq("sparse_first_src", out_src, 3);
        check_eq("sparse_first_data", out_data, 32'h0003_0002);
        tick();
        check_eq("sparse_second_src", out_src, 1);
        check_eq("sparse_second_data", out_data, 32'h0001_0002);
        tick();
        check_eq("sparse_done", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/output_port_arbiter_rr.md
Name: output_port_arbiter_rr

Overview:
Parametrised next-generation output port arbiter for the mesh router. It takes NUM_INPUTS packet sources (N/S/E/W ports plus cache return, and more for wider routers) and buffers each one in its own FIFO. A fair round-robin arbiter drains the FIFOs into a single registered output port that honours downstream back-pressure. It sits between the incoming port handlers / cache arbiter and one physical router output link. It replaces the drop-prone fixed-priority shared buffer.

Parameters:
NUM_INPUTS, 5, number of packet sources; index 0=N, 1=S, 2=E, 3=W, 4=cache; must be >=2.
DEST_W, 8, destination address width (network + cache-bank address).
REQ_W, 4, requester network address width.
DATA_W, 32, payload width.
FIFO_DEPTH, 4, entries per input FIFO; power of 2, >=2.
SRC_W, $clog2(NUM_INPUTS), width of the source-index field.

Ports:
clk  in  1  clock; all state updates on the falling edge (router fabric timing).
reset  in  1  asynchronous, active-high.
in_valid  in  NUM_INPUTS  per-input packet offer.
in_ready  out  NUM_INPUTS  per-input accept; the transfer happens when valid&&ready at the edge.
in_dest  in  NUM_INPUTS*DEST_W  packed destination addresses; input i occupies bits [i*DEST_W +: DEST_W].
in_req  in  NUM_INPUTS*REQ_W  packed requester addresses.
in_read  in  NUM_INPUTS  read flags.
in_write  in  NUM_INPUTS  write flags.
in_data  in  NUM_INPUTS*DATA_W  packed payloads.
out_valid  out  1  output packet present.
out_ready  in  1  downstream accepts.
out_dest / out_req / out_data  out  DEST_W / REQ_W / DATA_W  output packet fields.
out_read / out_write  out  1 / 1  output flags.
out_src  out  SRC_W  index of the input that supplied the current output packet.
fifo_full  out  NUM_INPUTS  per-FIFO full status, for debug and performance counters.

Behaviour:
- Reset (asynchronous): all FIFO pointers and counts go to 0; out_valid=0; out_read=0; out_write=0; out_dest=0; out_req=0; out_data=0; out_src=0; rr_ptr=0. in_ready is forced to 0 while reset is high. Reset asserted mid-operation flushes all buffered packets and discards the output register contents.
- Per-input FIFO: in_ready[i] = !full[i] (registered state only, no combinational path from out_ready). A push on a full FIFO is impossible by construction. Push and pop in the same cycle leave the count unchanged. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is $clog2(FIFO_DEPTH)+1 bits.
- Output register load condition: load = !out_valid || out_ready. When load is true and at least one FIFO is non-empty:
  - grant the first non-empty FIFO searching upward from rr_ptr, modulo NUM_INPUTS;
  - pop that FIFO, register its packet, set out_src = grant and out_valid=1;
  - set rr_ptr = grant+1, wrapping NUM_INPUTS-1 to 0.
- When load is true and all FIFOs are empty: out_valid goes to 0 at the edge, and the field registers hold their previous values.
- Stall: when out_valid && !out_ready, all output fields are held stable, no FIFO pops, and rr_ptr is held.
- Latency without bypass: an input accepted at edge T appears on the output after edge T+1 (2 falling edges from offer to output), provided there is no contention or stall.
- Fairness: with all inputs continuously valid, grants cycle 0,1,2,...,N-1,0. Worst-case wait is NUM_INPUTS-1 grants.
- Packet fields pass through unmodified. The block never drops a packet.

Optional Feature:
Macro OPA_BYPASS_EN.
- Defined: an input whose FIFO is empty and whose in_valid is high is also eligible in the round-robin search. If it is granted, its packet is written straight into the output register at the same edge and is not enqueued, giving 1-edge latency. in_ready still equals !full.
- Not defined: every packet passes through its FIFO, and latency is 2 edges.

Decomposition:
- Shared package/include (globalVariables.v): OPA_PORT_NORTH..OPA_PORT_CACHE index constants, default widths, and the packed-packet field offsets.
- One natural sub-module: opa_fifo (a single-clock FIFO of width DEST_W+REQ_W+2+DATA_W, depth FIFO_DEPTH, providing push/pop/full/empty/count). Instantiate it NUM_INPUTS times in a generate loop.
- The round-robin search stays inline in the top module.

Test Plan:
- Single input: N pushes dest=0x12, data=0xDEADBEEF with out_ready=1 -> out_valid after 2 edges, out_src=0, fields match exactly; 1 edge when OPA_BYPASS_EN is defined.
- All 5 inputs valid every cycle, out_ready=1, 20 cycles -> out_src sequence 0,1,2,3,4,0,... with no gaps after the first output.
- out_ready=0 with input 2 pushing continuously -> fifo_full[2] and in_ready[2]=0 after 4 accepts (5 with output register); output held stable. Release out_ready -> 5 packets emerge in order.
- FIFO wrap: push and pop input 1 simultaneously for 3*FIFO_DEPTH cycles with incrementing data 0..11 -> output data 0..11 in order, count never exceeds 1.
- Reset pulse asserted mid-stream with 3 packets buffered -> out_valid=0 and in_ready=0 immediately (asynchronous); after release no stale packet appears and rr_ptr restarts at 0.
- Sparse contention: inputs 1 and 3 valid together after rr_ptr=2 -> 3 granted first, then 1.
